// File: rtl/subseq_gen.sv
// Serial MSB-first word transmitter with a built-in overlapping pattern monitor.
// o_hit lines up cycle-exactly with a downstream detector's z on the same x stream.
module subseq_gen #(
    parameter int                WIDTH   = 8,
    parameter int                PLEN    = 5,
    parameter logic [PLEN-1:0]   PATTERN = 5'b10010,
    parameter int                CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    output logic             o_x,
    output logic             o_x_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_hit,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic [1:0]       o_state
);

    // Handshake: a word transfers on a rising edge where i_din_valid && o_din_ready;
    // o_din_ready depends only on state, never on i_din_valid.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

    localparam int                BC_W     = $clog2(WIDTH);
    localparam int                FILL_W   = $clog2(PLEN + 1);
    localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PLEN);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shreg;
    logic [BC_W-1:0]    r_bitcnt;
    logic [PLEN-1:0]    r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_hit;
    logic [CNT_W-1:0]   r_match_cnt;
    logic [PLEN-1:0]    w_hist_next;
    logic [FILL_W-1:0]  w_fill_next;
    logic               w_hit_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_din_ready  = 1'b0;
        o_x          = 1'b0;
        o_x_valid    = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_din_ready = 1'b1;
                if (i_din_valid) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                o_x       = r_shreg[WIDTH-1];
                o_x_valid = 1'b1;
                o_busy    = 1'b1;
                if (r_bitcnt == '0) w_state_next = S_DONE;
            end
            S_DONE: begin
                o_done       = 1'b1;
                o_busy       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_din_valid) begin
                        r_shreg  <= i_din;
                        r_bitcnt <= BC_LAST;
                    end
                end
                S_SHIFT: begin
                    r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The monitor samples the line itself, gap zeros included, as a detector would.
    assign w_hist_next = {r_hist[PLEN-2:0], o_x};
    assign w_fill_next = (r_fill < FILL_MAX) ? r_fill + 1'b1 : r_fill;
    assign w_hit_next  = (w_fill_next >= FILL_MAX) && (w_hist_next == PATTERN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_hit       <= 1'b0;
            r_match_cnt <= '0;
        end else begin
            r_hist <= w_hist_next;
            r_fill <= w_fill_next;
            r_hit  <= w_hit_next;
            if (w_hit_next && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign o_hit       = r_hit;
    assign o_match_cnt = r_match_cnt;
    assign o_state     = r_state;

endmodule

// File: doc/subseq_gen.md
Name: subseq_gen

Overview:
Serial pattern transmitter that feeds the 1-bit `x` line consumed by the team's overlapping sequence detector. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It also monitors its own output stream for PATTERN, overlapping occurrences included. `hit` asserts on the same cycle a downstream detector's `z` would assert, so benches can use it as a cycle-exact reference model.

Parameters:
WIDTH, 8, payload word width (>= 2)
PATTERN, 5'b10010, bit pattern monitored on the output stream (MSB emitted first)
PLEN, 5, PATTERN length in bits
CNT_W, 8, width of match counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  word to transmit
din_valid  input  1  din is valid
din_ready  output  1  block can accept a word this cycle
x  output  1  serial data line; 0 when not transmitting
x_valid  output  1  x carries a payload bit
busy  output  1  word in flight (SHIFT or DONE)
done  output  1  one-cycle pulse after last bit of a word
hit  output  1  the PLEN bits just emitted equal PATTERN
match_cnt  output  CNT_W  PATTERN occurrences emitted since reset, saturating

Behaviour:
- Reset (async, while rst=1): state=IDLE, shift reg=0, bit counter=0, history=0, fill counter=0. Outputs: din_ready=1, x=0, x_valid=0, busy=0, done=0, hit=0, match_cnt=0. Reset mid-word drops the word and its partial history.
- FSM states: IDLE, SHIFT, DONE. All outputs are decoded from registers; no combinational path from din/din_valid to any output.
- IDLE:
  - din_ready=1.
  - At an edge with din_valid=1: shreg<=din, bitcnt<=WIDTH-1, go to SHIFT. Call this edge E0.
  - din_valid is ignored in every other state.
- SHIFT:
  - x=shreg[WIDTH-1], x_valid=1, busy=1, din_ready=0.
  - Each edge: shreg shifts left (LSB fills 0), bitcnt decrements.
  - At the edge where bitcnt==0, go to DONE. That edge is E_WIDTH.
  - Bit i (i=0 is MSB) is driven during the cycle following E_i.
- DONE: one cycle. done=1, busy=1, x=0, x_valid=0, din_ready=0. Next edge goes to IDLE.
- Throughput: with din_valid held high, one word every WIDTH+2 cycles. Between words the line carries exactly two 0 bits (DONE cycle, then the IDLE cycle).
- Monitor:
  - Every edge, history<={history[PLEN-2:0], x}. Idle/DONE zeros are included, exactly as a detector sampling x would see them.
  - fill counts sampled bits, saturating at PLEN.
  - hit is registered: hit<=(fill_next>=PLEN) && (history_next==PATTERN).
  - Result: hit is high during the cycle after the edge that sampled the completing bit. This is the same alignment as the detector's z.
  - Overlapping matches all count.
  - The fill gate prevents false matches from reset zeros when PATTERN has leading zeros.
- match_cnt increments by 1 at each edge where hit_next=1. It holds at 2^CNT_W-1 and does not wrap.
- hit and match_cnt update in every state, including IDLE.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> outputs reach reset values (din_ready=1, x=0, x_valid=0, busy=0, done=0, hit=0, match_cnt=0) immediately, without waiting for a clock edge.
- Single word: din=8'b1001_0000 accepted at E0.
  - x = 1,0,0,1,0,0,0,0 in cycles 1..8; x_valid=1 for exactly 8 cycles.
  - done=1 in cycle 9 only; din_ready=1 again in cycle 10.
  - hit=1 in cycle 6 only; match_cnt=1.
- Overlap: din=8'b1001_0010 -> hit in cycles 6 and 9; match_cnt=2.
- Cross-word: din_valid held high.
  - Words 8'b0000_0001 then 8'b1000_0000: the stream ...1,0,0,1,0 spans the two-zero gap.
  - hit=1 the cycle after word 2 bit 1 is sampled; match_cnt=1; word 2 accepted at the IDLE edge right after done.
- Saturation: CNT_W=2, stream 6 words of 8'b1001_0000 -> match_cnt reaches 3 and stays 3; hit still pulses each match.
- Reset mid-word: rst after 3 bits of 8'b1001_0010.
  - Outputs return to reset values and match_cnt=0.
  - After release, din=8'b1001_0000 transmits as in the single-word case with hit in cycle 6; no match from the pre-reset bits.
